// File: rtl/interp_pkg.sv
// Shared types and size helpers for the pilot interpolation engine.
// Contents: FSM state enum, accumulator-source select enum, width helper
// functions and default-configuration localparams.
package interp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_LAST,
    ST_DONE
  } state_t;

  // Source of the next accumulator value.
  typedef enum logic [1:0] {
    ACC_ADD,     // acc + diff
    ACC_RELOAD,  // selected pilot scaled by STEP
    ACC_FINAL,   // last pilot scaled by STEP
    ACC_HOLD     // keep current value
  } acc_sel_t;

  function automatic int calc_idx_w(input int n_pilot, input int log2_step);
    return $clog2((n_pilot - 1) * (1 << log2_step) + 1);
  endfunction

  function automatic int calc_acc_w(input int in_width, input int log2_step);
    return in_width + log2_step + 1;
  endfunction

  function automatic int calc_diff_w(input int in_width);
    return in_width + 1;
  endfunction

  // Default configuration (IN_WIDTH=17, LOG2_STEP=2).
  localparam int STEP   = 1 << 2;
  localparam int ACC_W  = calc_acc_w(17, 2);
  localparam int DIFF_W = calc_diff_w(17);

endpackage

// File: rtl/interp_addend_mux.sv
// Accumulator next-value selector (combinational).
// Ports:
//   sel       - acc_sel_t code choosing the source
//   acc       - current accumulator (pilot scaled by STEP)
//   diff      - per-sample increment for the current segment
//   p_reload  - pilot to load as new segment start
//   p_final   - last pilot of the burst
//   acc_nxt   - selected next accumulator value
module interp_addend_mux
  import interp_pkg::*;
#(
  parameter int IN_WIDTH  = 17,
  parameter int LOG2_STEP = 2
) (
  input  logic [1:0]                     sel,
  input  logic signed [IN_WIDTH+LOG2_STEP:0] acc,
  input  logic signed [IN_WIDTH:0]       diff,
  input  logic signed [IN_WIDTH-1:0]     p_reload,
  input  logic signed [IN_WIDTH-1:0]     p_final,
  output logic signed [IN_WIDTH+LOG2_STEP:0] acc_nxt
);

  localparam int AW = calc_acc_w(IN_WIDTH, LOG2_STEP);

  function automatic logic signed [AW-1:0] scale(input logic signed [IN_WIDTH-1:0] p);
    return AW'(p) <<< LOG2_STEP;
  endfunction

  always_comb begin
    acc_nxt = acc;
    unique case (acc_sel_t'(sel))
      ACC_ADD:    acc_nxt = acc + AW'(diff);
      ACC_RELOAD: acc_nxt = scale(p_reload);
      ACC_FINAL:  acc_nxt = scale(p_final);
      default:    acc_nxt = acc;
    endcase
  end

endmodule

// File: rtl/interp_seq_engine.sv
// Sequential pilot-to-subcarrier interpolation engine (one real rail).
// Captures N_PILOT pilots on start, then streams (N_PILOT-1)*STEP+1
// linearly interpolated (mode=0) or zero-order-held (mode=1) samples
// over valid/ready. Shift-add arithmetic only.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   start       - burst request, sampled only in IDLE
//   mode        - 0 linear, 1 hold; captured with start
//   pilots      - flat bus, pilot p at [p*IN_WIDTH +: IN_WIDTH]
//   out_ready   - downstream accept
//   out_valid   - out_data/out_idx valid
//   out_data    - rounded sample, sign-extended to OUT_WIDTH
//   out_idx     - sample position 0..(N_PILOT-1)*STEP
//   busy        - high outside IDLE
//   done        - one-cycle pulse after the last sample is accepted
module interp_seq_engine
  import interp_pkg::*;
#(
  parameter int IN_WIDTH  = 17,
  parameter int OUT_WIDTH = 19,
  parameter int N_PILOT   = 4,
  parameter int LOG2_STEP = 2,
  parameter int IDX_W     = calc_idx_w(N_PILOT, LOG2_STEP)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          mode,
  input  logic [N_PILOT*IN_WIDTH-1:0]   pilots,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int SEG_STEP = 1 << LOG2_STEP;
  localparam int AW       = calc_acc_w(IN_WIDTH, LOG2_STEP);
  localparam int DW       = calc_diff_w(IN_WIDTH);
  localparam int SEG_W    = $clog2(N_PILOT);
  localparam int K_W      = (LOG2_STEP > 0) ? LOG2_STEP : 1;

  localparam logic [K_W-1:0]       K_LAST   = K_W'(SEG_STEP - 1);
  localparam logic [SEG_W-1:0]     SEG_LAST = SEG_W'(N_PILOT - 2);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'((N_PILOT - 1) * SEG_STEP);
  localparam logic signed [AW-1:0] ROUND    = AW'(SEG_STEP / 2);

  state_t                      state, state_nxt;
  logic signed [IN_WIDTH-1:0]  p_reg [N_PILOT];
  logic                        mode_reg;
  logic signed [AW-1:0]        acc, acc_nxt;
  logic signed [DW-1:0]        diff, diff_nxt, diff_seg;
  logic [SEG_W-1:0]            seg, seg_nxt;
  logic [K_W-1:0]              k, k_nxt;
  logic                        capture;
  acc_sel_t                    acc_sel;
  logic signed [IN_WIDTH-1:0]  p_left, p_right;
  logic                        hs;

  assign out_valid = (state == ST_RUN) || (state == ST_LAST);
  assign hs        = out_valid & out_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // Endpoints of the segment being entered: segment 0 from LOAD,
  // segment seg+1 from RUN.
  always_comb begin
    int unsigned base;
    base    = (state == ST_LOAD) ? 32'd0 : 32'(seg) + 32'd1;
    p_left  = '0;
    p_right = '0;
    for (int unsigned i = 0; i < N_PILOT; i++) begin
      if (i == base)         p_left  = p_reg[i];
      if (i == base + 32'd1) p_right = p_reg[i];
    end
    diff_seg = mode_reg ? '0 : DW'(p_right) - DW'(p_left);
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    acc_sel   = ACC_HOLD;
    seg_nxt   = seg;
    k_nxt     = k;
    diff_nxt  = diff;
    case (state)
      ST_IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        acc_sel   = ACC_RELOAD;
        seg_nxt   = '0;
        k_nxt     = '0;
        diff_nxt  = diff_seg;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (hs) begin
          if (k != K_LAST) begin
            acc_sel = ACC_ADD;
            k_nxt   = k + K_W'(1);
          end else if (seg != SEG_LAST) begin
            // Exact reload at each pilot keeps rounding error from accumulating.
            acc_sel  = ACC_RELOAD;
            seg_nxt  = seg + SEG_W'(1);
            k_nxt    = '0;
            diff_nxt = diff_seg;
          end else begin
            acc_sel   = ACC_FINAL;
            state_nxt = ST_LAST;
          end
        end
      end
      ST_LAST: begin
        if (hs) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_PILOT; i++) p_reg[i] <= '0;
      mode_reg <= 1'b0;
      acc      <= '0;
      diff     <= '0;
      seg      <= '0;
      k        <= '0;
    end else begin
      if (capture) begin
        for (int unsigned i = 0; i < N_PILOT; i++)
          p_reg[i] <= pilots[i*IN_WIDTH +: IN_WIDTH];
        mode_reg <= mode;
      end
      acc  <= acc_nxt;
      diff <= diff_nxt;
      seg  <= seg_nxt;
      k    <= k_nxt;
    end
  end

  interp_addend_mux #(
    .IN_WIDTH (IN_WIDTH),
    .LOG2_STEP(LOG2_STEP)
  ) u_mux (
    .sel     (acc_sel),
    .acc     (acc),
    .diff    (diff),
    .p_reload(p_left),
    .p_final (p_reg[N_PILOT-1]),
    .acc_nxt (acc_nxt)
  );

  // Round half toward +inf, then sign-extend.
  assign out_data = out_valid ? OUT_WIDTH'((acc + ROUND) >>> LOG2_STEP) : '0;

  always_comb begin
    out_idx = '0;
    if (state == ST_RUN)       out_idx = (IDX_W'(seg) << LOG2_STEP) + IDX_W'(k);
    else if (state == ST_LAST) out_idx = IDX_LAST;
  end

endmodule

// File: tb/tb_interp_seq_engine.sv
module tb_interp_seq_engine;

  localparam int IN_W  = 17;
  localparam int OUT_W = 19;
  localparam int NP    = 4;
  localparam int L2    = 2;
  localparam int STEP  = 4;
  localparam int NS    = (NP - 1) * STEP + 1;
  localparam int IDX_W = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 mode;
  logic [NP*IN_W-1:0]   pilots;
  logic                 out_ready;
  logic                 out_valid;
  logic [OUT_W-1:0]     out_data;
  logic [IDX_W-1:0]     out_idx;
  logic                 busy;
  logic                 done;

  always #5 clk = ~clk;

  interp_seq_engine #(
    .IN_WIDTH (IN_W),
    .OUT_WIDTH(OUT_W),
    .N_PILOT  (NP),
    .LOG2_STEP(L2),
    .IDX_W    (IDX_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .pilots   (pilots),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_idx  (out_idx),
    .busy     (busy),
    .done     (done)
  );

  int total = 0;
  int bad   = 0;

  int exp_d[$];
  int exp_i[$];
  int obs_d[$];
  bit done_due = 1'b0;
  bit hold_chk = 1'b0;
  int hold_d, hold_i;

  int p_lin[NP]  = '{0, 8, -8, 4};
  int p_ext[NP]  = '{65535, -65536, 65535, -65536};
  int p_alt[NP]  = '{100, -200, 300, -400};
  int lin_lit[NS]  = '{0, 2, 4, 6, 8, 4, 0, -4, -8, -5, -2, 1, 4};
  int hold_lit[NS] = '{0, 0, 0, 0, 8, 8, 8, 8, -8, -8, -8, -8, 4};

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int floor_div(input int n, input int d);
    int q;
    q = n / d;
    if ((n % d != 0) && ((n < 0) != (d < 0))) q--;
    return q;
  endfunction

  // Reference: sample i lies k/STEP of the way from P[s] to P[s+1],
  // rounded half toward +inf; last sample is the last pilot.
  task automatic build_model(input int p[NP], input bit m);
    exp_d.delete();
    exp_i.delete();
    for (int i = 0; i < NS; i++) begin
      int s, k, v;
      s = i / STEP;
      k = i % STEP;
      if (i == NS - 1) v = p[NP-1];
      else if (m)      v = p[s];
      else             v = floor_div(p[s] * STEP + k * (p[s+1] - p[s]) + STEP / 2, STEP);
      exp_d.push_back(v);
      exp_i.push_back(i);
    end
  endtask

  function automatic logic [NP*IN_W-1:0] pack(input int p[NP]);
    logic [NP*IN_W-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) r[i*IN_W +: IN_W] = IN_W'(p[i]);
    return r;
  endfunction

  // Per-cycle comparison against the model; called once per cycle at the
  // falling edge, with out_ready already set for the coming rising edge.
  task automatic compare();
    int d;
    d = int'($signed(out_data));
    check("done", done, done_due);
    done_due = 1'b0;
    if (hold_chk && out_valid) begin
      check("hold_data", d, hold_d);
      check("hold_idx", out_idx, hold_i);
    end
    hold_chk = 1'b0;
    if (out_valid) begin
      if (out_ready) begin
        if (exp_d.size() == 0) begin
          check("extra_sample", 1, 0);
        end else begin
          check("data", d, exp_d.pop_front());
          check("idx", out_idx, exp_i.pop_front());
          obs_d.push_back(d);
          if (exp_d.size() == 0) done_due = 1'b1;
        end
      end else begin
        hold_chk = 1'b1;
        hold_d   = d;
        hold_i   = out_idx;
      end
    end
  endtask

  task automatic step(input bit rdy, input bit st);
    out_ready = rdy;
    start     = st;
    compare();
    @(negedge clk);
  endtask

  task automatic run_burst(input int p[NP], input bit m, input bit bp, input bit ctl);
    int lat, cyc;
    bit seen;
    build_model(p, m);
    obs_d.delete();
    pilots = pack(p);
    mode   = m;
    step(1'b1, 1'b1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step(1'b1, 1'b0);
      lat++;
    end
    check("first_valid_latency", lat, 2);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 200) begin
      bit r, s;
      if (done) begin
        seen = 1'b1;
        break;
      end
      r = 1'b1;
      s = 1'b0;
      if (bp) r = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (ctl && cyc == 3) begin
        s      = 1'b1;
        pilots = pack(p_alt);
        mode   = ~m;
      end
      step(r, s);
      cyc++;
    end
    check("done_seen", seen, 1);
    check("samples_left", exp_d.size(), 0);
    // start while done is high must be ignored
    step(1'b1, 1'b1);
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
    step(1'b1, 1'b0);
    check("start_in_done_ignored", busy, 0);
  endtask

  task automatic check_obs(input string nm, input int lit[NS]);
    check({nm, "_count"}, obs_d.size(), NS);
    for (int i = 0; i < NS && i < obs_d.size(); i++)
      check($sformatf("%s[%0d]", nm, i), obs_d[i], lit[i]);
  endtask

  initial begin
    int c;
    rst_n     = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b0;
    pilots    = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Linear interpolation
    run_burst(p_lin, 1'b0, 1'b0, 1'b0);
    check_obs("linear", lin_lit);

    // Zero-order hold
    run_burst(p_lin, 1'b1, 1'b0, 1'b0);
    check_obs("hold", hold_lit);

    // Extremes
    run_burst(p_ext, 1'b0, 1'b0, 1'b0);
    check("ext_count", obs_d.size(), NS);
    if (obs_d.size() == NS) begin
      check("ext_idx0", obs_d[0], 65535);
      check("ext_idx1", obs_d[1], 32767);
      check("ext_idx2", obs_d[2], 0);
      check("ext_idx3", obs_d[3], -32768);
      check("ext_idx4", obs_d[4], -65536);
      check("ext_idx12", obs_d[12], -65536);
    end

    // Backpressure
    run_burst(p_lin, 1'b0, 1'b1, 1'b0);
    check_obs("backpressure", lin_lit);

    // start during RUN with other pilots/mode is ignored
    run_burst(p_lin, 1'b0, 1'b0, 1'b1);
    check_obs("start_in_run", lin_lit);

    // Reset in the middle of a burst
    build_model(p_lin, 1'b0);
    obs_d.delete();
    pilots = pack(p_lin);
    mode   = 1'b0;
    step(1'b1, 1'b1);
    c = 0;
    while (!(out_valid && out_idx == 5) && c < 30) begin
      step(1'b1, 1'b0);
      c++;
    end
    check("reach_idx5", (out_valid && out_idx == 5) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_data", out_data, 0);
    check("abort_idx", out_idx, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    exp_d.delete();
    exp_i.delete();
    done_due = 1'b0;
    hold_chk = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    check("post_abort_busy", busy, 0);

    // Clean burst after reset release
    run_burst(p_lin, 1'b0, 1'b0, 1'b0);
    check_obs("after_reset", lin_lit);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interp_seq_engine.md
Name: interp_seq_engine

Overview:
- Sequential pilot-to-subcarrier interpolation engine for NB-IoT channel estimation. It is the parametrised successor to the fixed 3-bit operand-select adder mux.
- Captures N_PILOT real-valued pilot estimates (one instance per I and Q rail). It then streams (N_PILOT-1)*2^LOG2_STEP+1 interpolated estimates over a valid/ready interface.
- Uses shift-add only, no multipliers. Sits between the pilot LS-estimate stage and the equaliser coefficient buffer.

Parameters:
- IN_WIDTH, 17, signed pilot estimate width.
- OUT_WIDTH, 19, signed output width. Must be >= IN_WIDTH. Output is sign-extended.
- N_PILOT, 4, number of pilots per burst. Must be >= 2.
- LOG2_STEP, 2, log2 of pilot spacing in output samples (STEP = 4).
- IDX_W, $clog2((N_PILOT-1)*(1<<LOG2_STEP)+1), output index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request. Sampled only in IDLE.
- mode  in  1  0 = linear interpolation, 1 = zero-order hold. Captured with start.
- pilots  in  N_PILOT*IN_WIDTH  flat signed bus. Pilot p occupies bits [p*IN_WIDTH +: IN_WIDTH]. Captured with start.
- out_ready  in  1  downstream accept.
- out_valid  out  1  out_data/out_idx valid.
- out_data  out  OUT_WIDTH  signed interpolated estimate.
- out_idx  out  IDX_W  sample position, 0..(N_PILOT-1)*STEP.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final sample is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs are 0; pilot registers, acc, diff, seg and k are cleared.
  - Reset mid-run aborts the burst immediately. No done pulse is produced.
- FSM states: IDLE, LOAD, RUN, LAST, DONE.
  - IDLE: start=1 captures pilots and mode, then goes to LOAD. busy rises the next cycle.
  - LOAD (1 cycle): seg=0, k=0, acc=P0<<<LOG2_STEP, diff=(mode ? 0 : P1-P0). Then goes to RUN.
  - RUN: out_valid=1. Advancement happens only on the handshake (out_valid & out_ready).
    - If k<STEP-1: acc+=diff, k++.
    - If k==STEP-1 and seg<N_PILOT-2: seg++, k=0, acc=P[seg+1]<<<LOG2_STEP (exact reload, no drift), diff recomputed for the new segment.
    - If k==STEP-1 and seg==N_PILOT-2: acc=P[N_PILOT-1]<<<LOG2_STEP, then goes to LAST.
  - LAST: out_valid=1, emits the final pilot. On handshake goes to DONE.
  - DONE (1 cycle): done=1, out_valid=0, then goes to IDLE.
- Latency: start at cycle t gives first out_valid at t+2. Throughput is 1 sample/cycle when out_ready is held high.
- Backpressure: while out_valid & !out_ready, out_data and out_idx hold stable. No internal state advances.
- out_idx = seg*STEP + k in RUN; (N_PILOT-1)*STEP in LAST.
- Arithmetic:
  - diff width IN_WIDTH+1, signed.
  - acc width IN_WIDTH+LOG2_STEP+1, signed.
  - out_data = (acc + 2^(LOG2_STEP-1)) >>> LOG2_STEP, i.e. round half toward +inf, then sign-extended to OUT_WIDTH.
  - When LOG2_STEP=0 there is no rounding term.
  - The result always lies between the segment endpoints, so no saturation logic is required.
- Simultaneous events: start outside IDLE is ignored, and mode/pilots are not re-captured. start in the same cycle as done is also ignored, since the FSM is in DONE.
- mode=1: diff forced to 0. Every sample in a segment equals the segment's left pilot; the last sample equals the final pilot.

Decomposition:
- Shared package interp_pkg:
  - state enum.
  - Function computing IDX_W.
  - Localparams STEP, ACC_W, DIFF_W.
- One sub-module: interp_addend_mux (combinational). Selects the acc next value from {acc+diff, P[seg+1]<<<LOG2_STEP, P[N_PILOT-1]<<<LOG2_STEP, hold}. This generalises the existing operand mux.
- The FSM, counters and handshake stay in the top level.

Test Plan:
- Linear, defaults, pilots {0,8,-8,4}, out_ready=1 → 13 samples, idx 0..12, data 0,2,4,6,8,4,0,-4,-8,-5,-2,1,4. done pulses one cycle after idx 12. First valid 2 cycles after start.
- Hold mode, same pilots → data 0,0,0,0,8,8,8,8,-8,-8,-8,-8,4.
- Extremes, pilots {65535,-65536,65535,-65536} → diff -131071 without overflow. Endpoints are exact; idx 2 gives 0 (-0.5 rounds to 0).
- Backpressure: toggle out_ready 1,0,0,1 during RUN → data/idx frozen while low. Sequence is identical to the first test and no sample is lost or duplicated.
- Control: start pulsed in RUN with different pilots is ignored. rst_n low at idx 5 gives all outputs 0 asynchronously and no done pulse. A new start after release produces a clean burst.
